// File: rtl/im2col_window_scheduler.sv
// im2col window scheduler.
// Walks a square KxK window across a WxH image with stride S in raster order
// (X fastest). Each window origin goes out on a one-cycle oWinDv strobe. The
// scheduler then waits for iWinDone from the downstream column generator before
// it advances to the next origin.
//
// Ports:
//   iClk, iRstN           clock, asynchronous active-low reset
//   iStart                request a pass (accepted only when idle)
//   iImgWidth/iImgHeight  image dimensions, latched on an accepted iStart
//   iKerWidth/iStride     kernel width and stride, latched on an accepted iStart
//   iWinDone              downstream finished the current window
//   oWinDv                window-issue strobe, qualifies oStartAddrX/Y, oKerWidth
//   oBusy                 pass in progress
//   oDone                 one-cycle end-of-pass pulse
//   oErr                  one-cycle pulse when a requested configuration is rejected
//   oWinCount             windows issued in the current or last pass
module im2col_window_scheduler #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_KER_W = 8,
  parameter int unsigned KER_W     = $clog2(MAX_KER_W) + 1
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic [ADDR_W-1:0]   iImgWidth,
  input  logic [ADDR_W-1:0]   iImgHeight,
  input  logic [KER_W-1:0]    iKerWidth,
  input  logic [KER_W-1:0]    iStride,
  input  logic                iWinDone,
  output logic                oWinDv,
  output logic [ADDR_W-1:0]   oStartAddrX,
  output logic [ADDR_W-1:0]   oStartAddrY,
  output logic [KER_W-1:0]    oKerWidth,
  output logic                oBusy,
  output logic                oDone,
  output logic                oErr,
  output logic [2*ADDR_W-1:0] oWinCount
);

  // One extra bit so origin + stride + kernel never wraps.
  localparam int unsigned SumW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   img_w_q, img_w_d, img_h_q, img_h_d;
  logic [ADDR_W-1:0]   x_q, x_d, y_q, y_d;
  logic [KER_W-1:0]    ker_q, ker_d, stride_q, stride_d;
  logic [2*ADDR_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [SumW-1:0] start_ker, ker_ext, stride_ext;
  logic [SumW-1:0] x_step, y_step, x_end, y_end;
  logic            cfg_ok;

  assign start_ker  = SumW'(iKerWidth);
  assign cfg_ok     = (iKerWidth != '0) && (32'(iKerWidth) <= MAX_KER_W) && (iStride != '0) &&
                      (start_ker <= SumW'(iImgWidth)) && (start_ker <= SumW'(iImgHeight));

  assign ker_ext    = SumW'(ker_q);
  assign stride_ext = SumW'(stride_q);
  assign x_step     = SumW'(x_q) + stride_ext;
  assign y_step     = SumW'(y_q) + stride_ext;
  assign x_end      = x_step + ker_ext;
  assign y_end      = y_step + ker_ext;

  always_comb begin
    state_d  = state_q;
    img_w_d  = img_w_q;
    img_h_d  = img_h_q;
    ker_d    = ker_q;
    stride_d = stride_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          img_w_d  = iImgWidth;
          img_h_d  = iImgHeight;
          ker_d    = iKerWidth;
          stride_d = iStride;
          x_d      = '0;
          y_d      = '0;
          cnt_d    = '0;
          err_d    = ~cfg_ok;
          state_d  = cfg_ok ? StIssue : StIdle;
        end
      end
      StIssue: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (iWinDone) begin
          if (x_end <= SumW'(img_w_q)) begin
            x_d     = x_step[ADDR_W-1:0];
            state_d = StIssue;
          end else if (y_end <= SumW'(img_h_q)) begin
            x_d     = '0;
            y_d     = y_step[ADDR_W-1:0];
            state_d = StIssue;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= StIdle;
      img_w_q  <= '0;
      img_h_q  <= '0;
      ker_q    <= '0;
      stride_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      img_w_q  <= img_w_d;
      img_h_q  <= img_h_d;
      ker_q    <= ker_d;
      stride_q <= stride_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign oWinDv      = (state_q == StIssue);
  assign oBusy       = (state_q == StIssue) || (state_q == StWait);
  assign oDone       = (state_q == StFin);
  assign oErr        = err_q;
  assign oStartAddrX = x_q;
  assign oStartAddrY = y_q;
  assign oKerWidth   = ker_q;
  assign oWinCount   = cnt_q;

endmodule

// File: tb/tb_im2col_window_scheduler.sv
// Bench for im2col_window_scheduler: expected window origins go into a queue
// when a pass is launched; a negedge monitor pops one entry per oWinDv strobe.
module tb_im2col_window_scheduler;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned KER_W  = 4;

  logic                iClk = 1'b0;
  logic                iRstN = 1'b0;
  logic                iStart = 1'b0;
  logic [ADDR_W-1:0]   iImgWidth = '0;
  logic [ADDR_W-1:0]   iImgHeight = '0;
  logic [KER_W-1:0]    iKerWidth = '0;
  logic [KER_W-1:0]    iStride = '0;
  logic                iWinDone = 1'b0;
  logic                oWinDv;
  logic [ADDR_W-1:0]   oStartAddrX;
  logic [ADDR_W-1:0]   oStartAddrY;
  logic [KER_W-1:0]    oKerWidth;
  logic                oBusy;
  logic                oDone;
  logic                oErr;
  logic [2*ADDR_W-1:0] oWinCount;

  im2col_window_scheduler #(
    .ADDR_W   (ADDR_W),
    .MAX_KER_W(8),
    .KER_W    (KER_W)
  ) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iStart     (iStart),
    .iImgWidth  (iImgWidth),
    .iImgHeight (iImgHeight),
    .iKerWidth  (iKerWidth),
    .iStride    (iStride),
    .iWinDone   (iWinDone),
    .oWinDv     (oWinDv),
    .oStartAddrX(oStartAddrX),
    .oStartAddrY(oStartAddrY),
    .oKerWidth  (oKerWidth),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oErr       (oErr),
    .oWinCount  (oWinCount)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [KER_W-1:0]  k;
  } win_t;

  win_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int k);
    win_t w;
    w.x = ADDR_W'(x);
    w.y = ADDR_W'(y);
    w.k = KER_W'(k);
    expQ.push_back(w);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge iClk) begin
    if (iRstN && oWinDv) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_strobe actual=(%0d,%0d) required=none", oStartAddrX,
                 oStartAddrY);
      end else begin
        win_t e;
        e = expQ.pop_front();
        chk("strobe_x", 32'(oStartAddrX), 32'(e.x));
        chk("strobe_y", 32'(oStartAddrY), 32'(e.y));
        chk("strobe_k", 32'(oKerWidth), 32'(e.k));
      end
    end
  end

  task automatic pulse_start(input int w, input int h, input int k, input int s);
    @(posedge iClk); #1;
    iImgWidth  = ADDR_W'(w);
    iImgHeight = ADDR_W'(h);
    iKerWidth  = KER_W'(k);
    iStride    = KER_W'(s);
    iStart     = 1'b1;
    @(posedge iClk); #1;
    iStart     = 1'b0;
    // Scramble the config inputs; the latched copy must be used.
    iImgWidth  = 8'd200;
    iImgHeight = 8'd200;
    iKerWidth  = 4'd1;
    iStride    = 4'd1;
  endtask

  // Expected origins must already be queued. Returns at the negedge after FIN.
  task automatic run_pass(input int w, input int h, input int k, input int s, input int n,
                          input bit dupStart, input bit stall);
    bit seen;
    pulse_start(w, h, k, s);
    @(negedge iClk);
    chk("first_strobe_latency", 32'(oWinDv), 1);
    chk("busy_in_issue", 32'(oBusy), 1);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk); #1;
      if (dupStart && i == 0) begin
        iImgWidth  = 8'd8;
        iImgHeight = 8'd8;
        iKerWidth  = 4'd2;
        iStride    = 4'd3;
        iStart     = 1'b1;
        @(posedge iClk); #1;
        iStart     = 1'b0;
        chk("busy_after_dup_start", 32'(oBusy), 1);
      end
      if (stall && i == 1) begin
        seen = 1'b0;
        repeat (20) begin
          @(negedge iClk);
          if (oWinDv || !oBusy) seen = 1'b1;
        end
        chk("stall_no_strobe", 32'(seen), 0);
        @(posedge iClk); #1;
      end
      iWinDone = 1'b1;
      @(posedge iClk); #1;
      iWinDone = 1'b0;
      @(negedge iClk);
      if (i < n - 1) begin
        chk("next_strobe_latency", 32'(oWinDv), 1);
      end else begin
        chk("done_pulse", 32'(oDone), 1);
        chk("busy_low_in_fin", 32'(oBusy), 0);
        chk("no_strobe_in_fin", 32'(oWinDv), 0);
      end
    end
    @(negedge iClk);
    chk("done_one_cycle", 32'(oDone), 0);
    chk("win_count", 32'(oWinCount), 32'(n));
    chk("queue_drained", 32'(expQ.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset state
    #3;
    chk("rst_wdv", 32'(oWinDv), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_done", 32'(oDone), 0);
    chk("rst_err", 32'(oErr), 0);
    chk("rst_count", 32'(oWinCount), 0);
    #21 iRstN = 1'b1;

    // 4x4, K=3, S=1
    push(0, 0, 3); push(1, 0, 3); push(0, 1, 3); push(1, 1, 3);
    run_pass(4, 4, 3, 1, 4, 1'b0, 1'b0);
    chk("hold_x", 32'(oStartAddrX), 1);
    chk("hold_y", 32'(oStartAddrY), 1);
    chk("hold_k", 32'(oKerWidth), 3);

    // 5x5, K=3, S=2
    push(0, 0, 3); push(2, 0, 3); push(0, 2, 3); push(2, 2, 3);
    run_pass(5, 5, 3, 2, 4, 1'b0, 1'b0);

    // Rejected: K=4 wider than W=3
    pulse_start(3, 8, 4, 1);
    @(negedge iClk);
    chk("err_pulse", 32'(oErr), 1);
    chk("err_busy", 32'(oBusy), 0);
    chk("err_count_cleared", 32'(oWinCount), 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge iClk);
      if (oErr || oBusy || oWinDv) seen = 1'b1;
    end
    chk("err_quiet", 32'(seen), 0);

    // Rejected: S=0
    pulse_start(8, 8, 2, 0);
    @(negedge iClk);
    chk("err_stride0", 32'(oErr), 1);

    // 3x3, K=3: single window
    push(0, 0, 3);
    run_pass(3, 3, 3, 1, 1, 1'b0, 1'b0);

    // Duplicate iStart in WAIT and a 20-cycle stall
    push(0, 0, 3); push(1, 0, 3); push(0, 1, 3); push(1, 1, 3);
    run_pass(4, 4, 3, 1, 4, 1'b1, 1'b1);

    // Reset in WAIT after two windows
    push(0, 0, 3); push(1, 0, 3);
    pulse_start(4, 4, 3, 1);
    @(negedge iClk);
    chk("rst_pass_strobe0", 32'(oWinDv), 1);
    @(posedge iClk); #1;
    iWinDone = 1'b1;
    @(posedge iClk); #1;
    iWinDone = 1'b0;
    @(negedge iClk);
    chk("rst_pass_strobe1", 32'(oWinDv), 1);
    @(posedge iClk); #3;
    chk("pre_rst_count", 32'(oWinCount), 2);
    iRstN = 1'b0;
    #1;
    chk("async_rst_x", 32'(oStartAddrX), 0);
    chk("async_rst_k", 32'(oKerWidth), 0);
    chk("async_rst_busy", 32'(oBusy), 0);
    chk("async_rst_count", 32'(oWinCount), 0);
    #20 iRstN = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge iClk); #1;
      iWinDone = ~iWinDone;
      @(negedge iClk);
      if (oWinDv || oDone || oBusy) seen = 1'b1;
    end
    iWinDone = 1'b0;
    chk("post_rst_quiet", 32'(seen), 0);
    chk("post_rst_queue", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
